// File: rtl/ddr_frame_aligner.sv
// Rebuilds octets from DDR nibble pairs at the correct phase and acquires frame
// lock on a sync word using a HUNT/PRESYNC/SYNC flywheel.
module ddr_frame_aligner #(
  parameter int                     PAD_WIDTH = 4,
  parameter logic [2*PAD_WIDTH-1:0] SYNC_WORD = 8'hF6,
  parameter int                     FRAME_LEN = 2430,
  parameter int                     CONFIRM   = 2,
  parameter int                     LOSS      = 4
) (
  input  logic                   inclock,
  input  logic                   rst,
  input  logic [PAD_WIDTH-1:0]   dataout_h,
  input  logic [PAD_WIDTH-1:0]   dataout_l,
  output logic [2*PAD_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_start,
  output logic                   locked,
  output logic                   phase
);

  localparam int W  = 2 * PAD_WIDTH;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(CONFIRM) + 1;
  localparam int MW = $clog2(LOSS) + 1;

  typedef enum logic [1:0] {
    HUNT,
    PRESYNC,
    SYNC
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [HW-1:0]   hit_cnt, hit_n, hit_inc;
  logic [MW-1:0]   miss_cnt, miss_n, miss_inc;
  logic            phase_n;
  logic [PAD_WIDTH-1:0] h_prev;
  logic [W-1:0]    cand0, cand1, sel;
  logic            check;

  // Phase 1 pairs last cycle's rising-edge nibble with this cycle's falling-edge one.
  always_comb begin
    cand0    = {dataout_l, dataout_h};
    cand1    = {h_prev, dataout_l};
    sel      = phase ? cand1 : cand0;
    cnt_inc  = (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + CW'(1);
    hit_inc  = hit_cnt + HW'(1);
    miss_inc = miss_cnt + MW'(1);
    check    = (cnt == '0);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hit_n   = hit_cnt;
    miss_n  = miss_cnt;
    phase_n = phase;
    case (state)
      HUNT: begin
        cnt_n = '0;
        if (cand0 == SYNC_WORD) begin
          phase_n = 1'b0;
          hit_n   = '0;
          cnt_n   = CW'(1);
          state_n = PRESYNC;
        end else if (cand1 == SYNC_WORD) begin
          phase_n = 1'b1;
          hit_n   = '0;
          cnt_n   = CW'(1);
          state_n = PRESYNC;
        end
      end
      PRESYNC: begin
        cnt_n = cnt_inc;
        if (check) begin
          if (sel == SYNC_WORD) begin
            hit_n = hit_inc;
            if (hit_inc == HW'(CONFIRM)) begin
              state_n = SYNC;
              miss_n  = '0;
            end
          end else begin
            state_n = HUNT;
            cnt_n   = '0;
          end
        end
      end
      SYNC: begin
        cnt_n = cnt_inc;
        if (check) begin
          if (sel == SYNC_WORD) begin
            miss_n = '0;
          end else begin
            miss_n = miss_inc;
            if (miss_inc == MW'(LOSS)) begin
              state_n = HUNT;
              cnt_n   = '0;
            end
          end
        end
      end
      default: begin
        state_n = HUNT;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge inclock) begin
    if (rst) begin
      state    <= HUNT;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      phase    <= 1'b0;
      h_prev   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hit_cnt  <= hit_n;
      miss_cnt <= miss_n;
      phase    <= phase_n;
      h_prev   <= dataout_h;
    end
  end

  // Outputs reflect the current cycle's state, so frame_start lines up with the sync word.
  always_ff @(posedge inclock) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      data_out    <= sel;
      data_valid  <= (state != HUNT);
      frame_start <= (state == SYNC) && check;
      locked      <= (state == SYNC);
    end
  end

endmodule

// File: tb/tb_ddr_frame_aligner.sv
// Scoreboard bench for ddr_frame_aligner: directed stimulus queues hand-timed
// expectations per edge, a negedge monitor pops and compares them.
module tb_ddr_frame_aligner;

  logic       inclock = 1'b0;
  logic       rst;
  logic [3:0] dataout_h, dataout_l;

  logic [7:0] data_out0, data_out1;
  logic       data_valid0, frame_start0, locked0, phase0;
  logic       data_valid1, frame_start1, locked1, phase1;

  typedef struct {
    int         edge_no;
    bit         unit;
    logic [7:0] data;
    logic       valid;
    logic       fs;
    logic       lk;
    logic       ph;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   edge_no  = 0;
  int   checks   = 0;
  int   failures = 0;

  ddr_frame_aligner #(
    .PAD_WIDTH(4), .SYNC_WORD(8'hF6), .FRAME_LEN(16), .CONFIRM(2), .LOSS(4)
  ) u_dut (
    .inclock(inclock), .rst(rst), .dataout_h(dataout_h), .dataout_l(dataout_l),
    .data_out(data_out0), .data_valid(data_valid0), .frame_start(frame_start0),
    .locked(locked0), .phase(phase0)
  );

  // A sync word of 66 lets both candidates match in one cycle, which F6 cannot.
  ddr_frame_aligner #(
    .PAD_WIDTH(4), .SYNC_WORD(8'h66), .FRAME_LEN(16), .CONFIRM(2), .LOSS(4)
  ) u_dut_eq (
    .inclock(inclock), .rst(rst), .dataout_h(dataout_h), .dataout_l(dataout_l),
    .data_out(data_out1), .data_valid(data_valid1), .frame_start(frame_start1),
    .locked(locked1), .phase(phase1)
  );

  always #5 inclock = ~inclock;

  task automatic queue_expect(input bit unit, input logic [7:0] data, input logic v,
                              input logic fs, input logic lk, input logic ph, input string tag);
    exp_t e;
    e.edge_no = edge_no + 1;
    e.unit    = unit;
    e.data    = data;
    e.valid   = v;
    e.fs      = fs;
    e.lk      = lk;
    e.ph      = ph;
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [3:0] l, input logic [3:0] h);
    dataout_l = l;
    dataout_h = h;
    @(posedge inclock);
    edge_no++;
    #1;
  endtask

  task automatic check_output(input exp_t e);
    logic [7:0] a_data;
    logic       a_v, a_fs, a_lk, a_ph;
    a_data = e.unit ? data_out1    : data_out0;
    a_v    = e.unit ? data_valid1  : data_valid0;
    a_fs   = e.unit ? frame_start1 : frame_start0;
    a_lk   = e.unit ? locked1      : locked0;
    a_ph   = e.unit ? phase1       : phase0;
    checks++;
    if ({a_data, a_v, a_fs, a_lk, a_ph} !== {e.data, e.valid, e.fs, e.lk, e.ph}) begin
      failures++;
      $display("[TB] FAIL %s edge=%0d unit=%0d got data=%h valid=%b fs=%b locked=%b phase=%b expected data=%h valid=%b fs=%b locked=%b phase=%b",
               e.tag, e.edge_no, e.unit, a_data, a_v, a_fs, a_lk, a_ph,
               e.data, e.valid, e.fs, e.lk, e.ph);
    end
  endtask

  always @(negedge inclock) begin
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_no) begin
      cur = exp_q.pop_front();
      if (cur.edge_no < edge_no) begin
        checks++;
        failures++;
        $display("[TB] FAIL stale_%s edge=%0d got not_sampled expected sampled", cur.tag, cur.edge_no);
      end else begin
        check_output(cur);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      queue_expect(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
      queue_expect(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset_eq");
      apply_stimulus(4'h0, 4'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      queue_expect(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
      queue_expect(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "idle_eq");
      apply_stimulus(4'h0, 4'h0);
    end
  endtask

  initial begin
    bit   drop, sync;
    int   dp;
    logic [7:0] ed;
    rst       = 1'b1;
    dataout_h = 4'h0;
    dataout_l = 4'h0;

    // Phase 0 acquisition, then 3 dropped words (held), then 4 dropped (lost).
    do_reset();
    for (int d = 0; d <= 200; d++) begin
      drop = (d == 64) || (d == 80) || (d == 96) || (d == 144) ||
             (d == 160) || (d == 176) || (d == 192);
      sync = (d % 16 == 0) && !drop;
      queue_expect(1'b0, sync ? 8'hF6 : 8'h00, (d >= 1) && (d <= 192),
                   (d % 16 == 0) && (d >= 48) && (d <= 192),
                   (d >= 33) && (d <= 192), 1'b0, "phase0_flywheel");
      apply_stimulus(sync ? 4'hF : 4'h0, sync ? 4'h6 : 4'h0);
    end

    // Phase 1 acquisition; reset at a locked sync position, then re-acquire.
    do_reset();
    for (int d = 0; d <= 150; d++) begin
      if (d == 81) begin
        rst = 1'b1;
        queue_expect(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "midlock_reset");
      end else begin
        dp = (d < 81) ? d : d - 96;
        if (dp < 0) begin
          queue_expect(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_hunt");
        end else begin
          ed = (dp == 0) ? 8'h0F : (dp == 1) ? 8'h60 : (dp % 16 == 1) ? 8'hF6 : 8'h00;
          queue_expect(1'b0, ed, dp >= 2, (dp >= 49) && (dp % 16 == 1), dp >= 34,
                       dp >= 1, "phase1_acq");
        end
      end
      apply_stimulus((d % 16 == 1) ? 4'h6 : 4'h0, (d % 16 == 0) ? 4'hF : 4'h0);
      rst = 1'b0;
    end

    // False hit, then a hit on the very cycle HUNT is re-entered.
    do_reset();
    for (int d = 0; d <= 45; d++) begin
      sync = (d == 0) || (d == 17);
      queue_expect(1'b0, sync ? 8'hF6 : 8'h00,
                   ((d >= 1) && (d <= 16)) || ((d >= 18) && (d <= 33)),
                   1'b0, 1'b0, 1'b0, "false_hit");
      apply_stimulus(sync ? 4'hF : 4'h0, sync ? 4'h6 : 4'h0);
    end

    // Both candidates match together: phase 0 must win.
    do_reset();
    queue_expect(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, "simul_pre");
    apply_stimulus(4'h0, 4'h6);
    queue_expect(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, "simul_hit");
    apply_stimulus(4'h6, 4'h6);
    for (int d = 2; d <= 5; d++) begin
      queue_expect(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "simul_after");
      apply_stimulus(4'h0, 4'h0);
    end

    apply_stimulus(4'h0, 4'h0);
    apply_stimulus(4'h0, 4'h0);
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
